// File: rtl/sig_pkg.sv
// Lamp encodings, phase codes and the phase-to-lamp decode shared by the
// intersection controllers and their benches.
`timescale 1ns/1ps
package sig_pkg;

  localparam logic [1:0] SIG_RED    = 2'd0;
  localparam logic [1:0] SIG_YELLOW = 2'd1;
  localparam logic [1:0] SIG_GREEN  = 2'd2;

  typedef enum logic [2:0] {
    ST_HG     = 3'd0,
    ST_HY     = 3'd1,
    ST_AR1    = 3'd2,
    ST_CG     = 3'd3,
    ST_CY     = 3'd4,
    ST_WK     = 3'd5,
    ST_AR2    = 3'd6,
    ST_UNUSED = 3'd7
  } phase_e;

  typedef struct packed {
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       walk;
  } lamps_t;

  function automatic lamps_t decode_lamps(phase_e s);
    lamps_t l;
    l = '{hwy: SIG_RED, cntry: SIG_RED, walk: 1'b0};
    case (s)
      ST_HG:   l.hwy   = SIG_GREEN;
      ST_HY:   l.hwy   = SIG_YELLOW;
      ST_CG:   l.cntry = SIG_GREEN;
      ST_CY:   l.cntry = SIG_YELLOW;
      ST_WK:   l.walk  = 1'b1;
      default: l = '{hwy: SIG_RED, cntry: SIG_RED, walk: 1'b0};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/sig_phase_sched_if.sv
// Sensor inputs and lamp/monitor outputs of the phase scheduler.
// SIG_PREEMPT_EN adds the preempt input.
`timescale 1ns/1ps
interface sig_phase_sched_if;
  logic       car_x;
  logic       ped_req;
`ifdef SIG_PREEMPT_EN
  logic       preempt;
`endif
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  modport master (
`ifdef SIG_PREEMPT_EN
    output preempt,
`endif
    output car_x, ped_req,
    input  hwy, cntry, walk, ped_pending, phase
  );

  modport slave (
`ifdef SIG_PREEMPT_EN
    input  preempt,
`endif
    input  car_x, ped_req,
    output hwy, cntry, walk, ped_pending, phase
  );
endinterface

// File: rtl/sig_phase_timer.sv
// Loadable down-counter that saturates at zero; zero flags the last cycle of a phase.
`timescale 1ns/1ps
module sig_phase_timer #(
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          clear_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)          cnt_q <= '0;
    else if (load)         cnt_q <= load_val;
    else if (cnt_q != '0)  cnt_q <= cnt_q - CW'(1);
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sig_phase_sched.sv
// Highway/country-road phase scheduler: FSM, car/pedestrian round-robin arbiter
// and pedestrian request latch. SIG_PREEMPT_EN adds emergency preemption.
`timescale 1ns/1ps
module sig_phase_sched
  import sig_pkg::*;
#(
  parameter int CW        = 8,
  parameter int HWY_MIN   = 20,
  parameter int Y_TIME    = 3,
  parameter int AR_TIME   = 2,
  parameter int CNTRY_MAX = 10,
  parameter int WALK_TIME = 8
) (
  input logic              clock,
  input logic              clear_n,
  sig_phase_sched_if.slave bus
);

  localparam logic [CW-1:0] T_HG       = CW'(HWY_MIN - 1);
  localparam logic [CW-1:0] T_HG_FRESH = CW'((HWY_MIN > 1) ? HWY_MIN - 2 : 0);
  localparam logic [CW-1:0] T_Y        = CW'(Y_TIME - 1);
  localparam logic [CW-1:0] T_AR       = CW'(AR_TIME - 1);
  localparam logic [CW-1:0] T_CG       = CW'(CNTRY_MAX - 1);
  localparam logic [CW-1:0] T_WK       = CW'(WALK_TIME - 1);
  localparam logic          HG_MIN_ONE = (HWY_MIN == 1);

  phase_e        state_q, state_d;
  logic          fresh_q, ped_pending_q, target_ped_q, last_ped_q;
  logic          capture, pick_ped, preempt_on, hold_hg, hg_zero;
  logic          tmr_load, tmr_zero;
  logic [CW-1:0] tmr_val;
  lamps_t        lamps;

  function automatic logic [CW-1:0] dur(phase_e s);
    case (s)
      ST_HY, ST_CY:   return T_Y;
      ST_AR1, ST_AR2: return T_AR;
      ST_CG:          return T_CG;
      ST_WK:          return T_WK;
      default:        return T_HG;
    endcase
  endfunction

`ifdef SIG_PREEMPT_EN
  assign preempt_on = bus.preempt;
`else
  assign preempt_on = 1'b0;
`endif

  // The cycle right after reset release acts as the HG entry cycle, so the
  // reset-time timer value of 0 must not count as an expired min-green.
  assign hg_zero  = fresh_q ? HG_MIN_ONE : tmr_zero;
  assign pick_ped = ped_pending_q & (~bus.car_x | ~last_ped_q);
  assign hold_hg  = preempt_on && (state_q == ST_HG);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_HG:  if (!preempt_on && hg_zero && (bus.car_x || ped_pending_q)) begin
                state_d = ST_HY;
                capture = 1'b1;
              end
      ST_HY:  if (tmr_zero) state_d = ST_AR1;
      ST_AR1: if (tmr_zero) state_d = preempt_on   ? ST_HG :
                                      target_ped_q ? ST_WK : ST_CG;
      ST_CG:  if (preempt_on || !bus.car_x || tmr_zero) state_d = ST_CY;
      ST_CY:  if (tmr_zero) state_d = ST_AR2;
      ST_WK:  if (preempt_on || tmr_zero) state_d = ST_AR2;
      ST_AR2: if (tmr_zero) state_d = ST_HG;
      default: state_d = ST_HG;
    endcase
  end

  assign tmr_load = fresh_q || hold_hg || (state_d != state_q);
  assign tmr_val  = (fresh_q && !hold_hg && state_d == ST_HG) ? T_HG_FRESH : dur(state_d);

  sig_phase_timer #(.CW(CW)) u_timer (
    .clock    (clock),
    .clear_n  (clear_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q       <= ST_HG;
      fresh_q       <= 1'b1;
      ped_pending_q <= 1'b0;
      target_ped_q  <= 1'b0;
      last_ped_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fresh_q <= 1'b0;
      if (capture) begin
        target_ped_q <= pick_ped;
        last_ped_q   <= pick_ped;
      end
      // A press on the WK-entry cycle re-latches for the next round.
      if (bus.ped_req)                                ped_pending_q <= 1'b1;
      else if (state_d == ST_WK && state_q != ST_WK)  ped_pending_q <= 1'b0;
    end
  end

  assign lamps           = decode_lamps(state_q);
  assign bus.hwy         = lamps.hwy;
  assign bus.cntry       = lamps.cntry;
  assign bus.walk        = lamps.walk;
  assign bus.ped_pending = ped_pending_q;
  assign bus.phase       = state_q;

endmodule
